// File: rtl/tag_allocator_if.sv
// Port bundle for tag_allocator: tag read port, allocation request, victim writeback,
// completion strobe, dirty marking and flash invalidate. Signal names match the flat ports.
interface tag_allocator_if #(
    parameter int NUM_SET  = 32,
    parameter int NUM_WAY  = 2,
    parameter int TAG_BITS = 24
);
    localparam int SET_BITS = $clog2(NUM_SET);

    logic [SET_BITS-1:0]         probe_set_i;
    logic [TAG_BITS*NUM_WAY-1:0] tag_of_set_o;
    logic [NUM_WAY-1:0]          valid_of_way_o;

    logic                        alloc_valid_i;
    logic                        alloc_ready_o;
    logic [SET_BITS-1:0]         alloc_set_i;
    logic [TAG_BITS-1:0]         alloc_tag_i;

    logic                        evict_valid_o;
    logic                        evict_ready_i;
    logic [SET_BITS-1:0]         evict_set_o;
    logic [TAG_BITS-1:0]         evict_tag_o;
    logic [NUM_WAY-1:0]          evict_way_o;

    logic                        done_valid_o;
    logic [NUM_WAY-1:0]          done_way_o;

    logic                        mark_dirty_i;
    logic [SET_BITS-1:0]         mark_set_i;
    logic [NUM_WAY-1:0]          mark_waymask_i;

    logic                        invalidate_all_i;

    modport master (
        output probe_set_i, alloc_valid_i, alloc_set_i, alloc_tag_i, evict_ready_i,
               mark_dirty_i, mark_set_i, mark_waymask_i, invalidate_all_i,
        input  tag_of_set_o, valid_of_way_o, alloc_ready_o, evict_valid_o, evict_set_o,
               evict_tag_o, evict_way_o, done_valid_o, done_way_o
    );

    modport slave (
        input  probe_set_i, alloc_valid_i, alloc_set_i, alloc_tag_i, evict_ready_i,
               mark_dirty_i, mark_set_i, mark_waymask_i, invalidate_all_i,
        output tag_of_set_o, valid_of_way_o, alloc_ready_o, evict_valid_o, evict_set_o,
               evict_tag_o, evict_way_o, done_valid_o, done_way_o
    );
endinterface

// File: rtl/tag_allocator.sv
// Set-associative tag/valid store with invalid-first, round-robin victim allocation.
// Define TAG_ALLOC_WRITEBACK_EN to add dirty tracking and the dirty-victim EVICT handshake.
module tag_allocator #(
    parameter int NUM_SET  = 32,
    parameter int NUM_WAY  = 2,
    parameter int TAG_BITS = 24
) (
    input logic            clk,
    input logic            rst,
    tag_allocator_if.slave bus
);
    localparam int SET_BITS = $clog2(NUM_SET);
    localparam int PTR_BITS = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;

    typedef enum logic [1:0] {IDLE, SELECT, EVICT, WRITE} state_t;
    state_t state_q, state_d;

    logic [TAG_BITS-1:0] tag_q   [NUM_SET][NUM_WAY];
    logic [NUM_WAY-1:0]  valid_q [NUM_SET];
    logic [PTR_BITS-1:0] ptr_q   [NUM_SET];

    logic [SET_BITS-1:0] req_set_q;
    logic [TAG_BITS-1:0] req_tag_q;
    logic [NUM_WAY-1:0]  victim_q;
    logic                from_ptr_q;

    logic [NUM_WAY-1:0]  pick;
    logic                pick_from_ptr;
    logic                pick_dirty;

`ifdef TAG_ALLOC_WRITEBACK_EN
    logic [NUM_WAY-1:0]  dirty_q [NUM_SET];
    logic [TAG_BITS-1:0] evict_tag_q;
    // Only a pointer-selected victim can be valid, so only its dirty bit matters.
    assign pick_dirty = pick_from_ptr && dirty_q[req_set_q][ptr_q[req_set_q]];
`else
    logic unused_mark;
    assign pick_dirty  = 1'b0;
    assign unused_mark = ^{bus.mark_dirty_i, bus.mark_set_i, bus.mark_waymask_i};
`endif

    always_comb begin
        pick          = '0;
        pick_from_ptr = 1'b1;
        for (int unsigned w = 0; w < NUM_WAY; w++) begin
            if (pick_from_ptr && !valid_q[req_set_q][w]) begin
                pick[w]       = 1'b1;
                pick_from_ptr = 1'b0;
            end
        end
        if (pick_from_ptr) pick[ptr_q[req_set_q]] = 1'b1;
    end

    always_comb begin
        state_d           = state_q;
        bus.alloc_ready_o = 1'b0;
        bus.done_valid_o  = 1'b0;
        bus.done_way_o    = '0;
        bus.evict_valid_o = 1'b0;
        bus.evict_set_o   = '0;
        bus.evict_tag_o   = '0;
        bus.evict_way_o   = '0;
        unique case (state_q)
            IDLE: begin
                bus.alloc_ready_o = 1'b1;
                if (bus.alloc_valid_i) state_d = SELECT;
            end
            SELECT: state_d = pick_dirty ? EVICT : WRITE;
            EVICT: begin
`ifdef TAG_ALLOC_WRITEBACK_EN
                bus.evict_valid_o = 1'b1;
                bus.evict_set_o   = req_set_q;
                bus.evict_tag_o   = evict_tag_q;
                bus.evict_way_o   = victim_q;
`endif
                if (bus.evict_ready_i) state_d = WRITE;
            end
            WRITE: begin
                bus.done_valid_o = 1'b1;
                bus.done_way_o   = victim_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            req_set_q  <= '0;
            req_tag_q  <= '0;
            victim_q   <= '0;
            from_ptr_q <= 1'b0;
`ifdef TAG_ALLOC_WRITEBACK_EN
            evict_tag_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.alloc_valid_i) begin
                req_set_q <= bus.alloc_set_i;
                req_tag_q <= bus.alloc_tag_i;
            end
            if (state_q == SELECT) begin
                victim_q   <= pick;
                from_ptr_q <= pick_from_ptr;
`ifdef TAG_ALLOC_WRITEBACK_EN
                evict_tag_q <= tag_q[req_set_q][ptr_q[req_set_q]];
`endif
            end
        end
    end

    // Update order gives priority WRITE > invalidate > mark for the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < NUM_SET; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
`ifdef TAG_ALLOC_WRITEBACK_EN
                dirty_q[s] <= '0;
`endif
                for (int unsigned w = 0; w < NUM_WAY; w++) tag_q[s][w] <= '0;
            end
        end else begin
`ifdef TAG_ALLOC_WRITEBACK_EN
            if (bus.mark_dirty_i)
                dirty_q[bus.mark_set_i] <= dirty_q[bus.mark_set_i]
                                         | (bus.mark_waymask_i & valid_q[bus.mark_set_i]);
`endif
            if (bus.invalidate_all_i) begin
                for (int unsigned s = 0; s < NUM_SET; s++) begin
                    valid_q[s] <= '0;
`ifdef TAG_ALLOC_WRITEBACK_EN
                    dirty_q[s] <= '0;
`endif
                end
            end
            if (state_q == WRITE) begin
                for (int unsigned w = 0; w < NUM_WAY; w++) begin
                    if (victim_q[w]) begin
                        tag_q[req_set_q][w]   <= req_tag_q;
                        valid_q[req_set_q][w] <= 1'b1;
`ifdef TAG_ALLOC_WRITEBACK_EN
                        dirty_q[req_set_q][w] <= 1'b0;
`endif
                    end
                end
                if (from_ptr_q)
                    ptr_q[req_set_q] <= (ptr_q[req_set_q] == PTR_BITS'(NUM_WAY - 1))
                                      ? '0 : ptr_q[req_set_q] + 1'b1;
            end
        end
    end

    always_comb begin
        bus.tag_of_set_o = '0;
        for (int unsigned w = 0; w < NUM_WAY; w++)
            bus.tag_of_set_o[TAG_BITS*w +: TAG_BITS] = tag_q[bus.probe_set_i][w];
    end

    assign bus.valid_of_way_o = valid_q[bus.probe_set_i];

endmodule

// File: tb/tb_tag_allocator.sv
// Self-checking bench for tag_allocator (4 sets x 4 ways x 8-bit tags) against a
// behavioural cache-allocation model; adapts to whether TAG_ALLOC_WRITEBACK_EN is defined.
module tb_tag_allocator;
    localparam int NS = 4;
    localparam int NW = 4;
    localparam int TB = 8;
`ifdef TAG_ALLOC_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic clk;
    logic rst;
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    bit          m_valid [NS][NW];
    bit          m_dirty [NS][NW];
    logic [7:0]  m_tag   [NS][NW];
    int unsigned m_ptr   [NS];

    tag_allocator_if #(.NUM_SET(NS), .NUM_WAY(NW), .TAG_BITS(TB)) bus ();

    tag_allocator #(.NUM_SET(NS), .NUM_WAY(NW), .TAG_BITS(TB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = 8'h00;
            end
        end
    endtask

    task automatic model_inval();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
    endtask

    task automatic probe_check(input int unsigned s);
        logic [31:0] et;
        logic [3:0]  ev;
        for (int w = 0; w < NW; w++) begin
            et[8*w +: 8] = m_tag[s][w];
            ev[w]        = m_valid[s][w];
        end
        bus.probe_set_i = 2'(s);
        #1;
        chk("probe_valid", 32'(bus.valid_of_way_o), 32'(ev));
        chk("probe_tags", bus.tag_of_set_o, et);
    endtask

    task automatic mark(input int unsigned s, input logic [3:0] mask);
        bus.mark_dirty_i   = 1'b1;
        bus.mark_set_i     = 2'(s);
        bus.mark_waymask_i = mask;
        step();
        bus.mark_dirty_i   = 1'b0;
        if (WB)
            for (int w = 0; w < NW; w++)
                if (mask[w] && m_valid[s][w]) m_dirty[s][w] = 1'b1;
    endtask

    // One allocation; alloc_valid_i stays high until the completion strobe.
    task automatic do_alloc(input int unsigned s, input logic [7:0] t,
                            input int unsigned hold, input bit inval);
        int unsigned v;
        bit          from_ptr;
        bit          ev;
        bit          acc;
        logic [3:0]  oh;
        v        = m_ptr[s];
        from_ptr = 1'b1;
        for (int w = NW - 1; w >= 0; w--)
            if (!m_valid[s][w]) begin
                v        = w;
                from_ptr = 1'b0;
            end
        ev = WB && m_valid[s][v] && m_dirty[s][v];
        oh = 4'b0001 << v;

        bus.alloc_valid_i = 1'b1;
        bus.alloc_set_i   = 2'(s);
        bus.alloc_tag_i   = t;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = bus.alloc_ready_o;
            step();
        end
        if (!acc) begin
            chk("alloc_accept_timeout", 32'd0, 32'd1);
            bus.alloc_valid_i = 1'b0;
            return;
        end

        chk("ready_in_select", 32'(bus.alloc_ready_o), 32'd0);
        chk("done_in_select", 32'(bus.done_valid_o), 32'd0);
        step();

        if (ev) begin
            for (int unsigned i = 0; i <= hold; i++) begin
                chk("evict_valid", 32'(bus.evict_valid_o), 32'd1);
                chk("evict_set", 32'(bus.evict_set_o), 32'(s));
                chk("evict_tag", 32'(bus.evict_tag_o), 32'(m_tag[s][v]));
                chk("evict_way", 32'(bus.evict_way_o), 32'(oh));
                chk("done_in_evict", 32'(bus.done_valid_o), 32'd0);
                chk("ready_in_evict", 32'(bus.alloc_ready_o), 32'd0);
                if (i == hold) bus.evict_ready_i = 1'b1;
                if (inval && i == 0) bus.invalidate_all_i = 1'b1;
                step();
                bus.evict_ready_i    = 1'b0;
                bus.invalidate_all_i = 1'b0;
                if (inval && i == 0) model_inval();
            end
        end else begin
            chk("evict_idle", 32'(bus.evict_valid_o), 32'd0);
            if (inval) bus.invalidate_all_i = 1'b1;
        end

        chk("done_valid", 32'(bus.done_valid_o), 32'd1);
        chk("done_way", 32'(bus.done_way_o), 32'(oh));
        chk("ready_in_write", 32'(bus.alloc_ready_o), 32'd0);
        chk("evict_in_write", 32'(bus.evict_valid_o), 32'd0);
        bus.alloc_valid_i = 1'b0;
        if (!inval || ev) probe_check(s);
        step();
        bus.invalidate_all_i = 1'b0;
        if (inval && !ev) model_inval();
        m_tag[s][v]   = t;
        m_valid[s][v] = 1'b1;
        m_dirty[s][v] = 1'b0;
        if (from_ptr) m_ptr[s] = (m_ptr[s] + 1) % NW;
        chk("done_after", 32'(bus.done_valid_o), 32'd0);
        chk("ready_after", 32'(bus.alloc_ready_o), 32'd1);
    endtask

    initial begin
        rst                  = 1'b1;
        bus.probe_set_i      = '0;
        bus.alloc_valid_i    = 1'b0;
        bus.alloc_set_i      = '0;
        bus.alloc_tag_i      = '0;
        bus.evict_ready_i    = 1'b0;
        bus.mark_dirty_i     = 1'b0;
        bus.mark_set_i       = '0;
        bus.mark_waymask_i   = '0;
        bus.invalidate_all_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        chk("rst_ready", 32'(bus.alloc_ready_o), 32'd1);
        chk("rst_evict_valid", 32'(bus.evict_valid_o), 32'd0);
        chk("rst_done_valid", 32'(bus.done_valid_o), 32'd0);
        chk("rst_done_way", 32'(bus.done_way_o), 32'd0);
        chk("rst_evict_way", 32'(bus.evict_way_o), 32'd0);
        chk("rst_evict_set", 32'(bus.evict_set_o), 32'd0);
        chk("rst_evict_tag", 32'(bus.evict_tag_o), 32'd0);
        for (int s = 0; s < NS; s++) probe_check(s);
        rst = 1'b0;
        step();

        // Fill set 1, then round-robin replacement.
        for (int i = 0; i < 4; i++) do_alloc(1, 8'(8'h11 + i), 0, 1'b0);
        bus.probe_set_i = 2'd1;
        #1;
        chk("fill_valid", 32'(bus.valid_of_way_o), 32'hF);
        chk("fill_tags", bus.tag_of_set_o, 32'h14131211);
        do_alloc(1, 8'h55, 0, 1'b0);
        do_alloc(1, 8'h56, 0, 1'b0);

        // Dirty victim at the pointer, long writeback stall, flash invalidate during EVICT.
        mark(1, 4'b0100);
        do_alloc(1, 8'h66, 5, 1'b1);
        bus.probe_set_i = 2'd1;
        #1;
        chk("inval_valid", 32'(bus.valid_of_way_o), 32'b0100);
        chk("inval_tag_way2", 32'(bus.tag_of_set_o[23:16]), 32'h66);
        for (int s = 0; s < NS; s++) probe_check(s);

        for (int i = 0; i < 48; i++) begin
            int unsigned s;
            s = $urandom_range(NS - 1, 0);
            if ($urandom_range(1, 0) == 1) mark(s, 4'($urandom));
            do_alloc(s, 8'($urandom), $urandom_range(3, 0), $urandom_range(9, 0) == 0);
            probe_check($urandom_range(NS - 1, 0));
        end

        // Reset while an allocation sits in SELECT.
        do_alloc(2, 8'hA5, 0, 1'b0);
        bus.probe_set_i   = 2'd2;
        bus.alloc_valid_i = 1'b1;
        bus.alloc_set_i   = 2'd2;
        bus.alloc_tag_i   = 8'h77;
        step();
        chk("select_before_rst", 32'(bus.alloc_ready_o), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(bus.alloc_ready_o), 32'd1);
        chk("midrst_done", 32'(bus.done_valid_o), 32'd0);
        chk("midrst_valid", 32'(bus.valid_of_way_o), 32'd0);
        bus.alloc_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("midrst_no_done", 32'(bus.done_valid_o), 32'd0);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postrst_no_done", 32'(bus.done_valid_o), 32'd0);
        end
        probe_check(2);
        do_alloc(2, 8'h3C, 0, 1'b0);
        probe_check(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tag_allocator.md
TAG_ALLOCATOR -- requirements
Module: tag_allocator

Interface
REQ-001 SHALL have parameter NUM_SET, default 32, meaning number of sets (power of two).
REQ-002 SHALL have parameter NUM_WAY, default 2, meaning ways per set.
REQ-003 SHALL have parameter TAG_BITS, default 24, meaning tag width; SET_BITS is derived as log2(NUM_SET).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port probe_set_i  in  SET_BITS  set index for the tag read port.
REQ-007 SHALL have port tag_of_set_o  out  TAG_BITS*NUM_WAY  tags of probe_set_i, way i at bits [TAG_BITS*(i+1)-1 -: TAG_BITS]; combinational.
REQ-008 SHALL have port valid_of_way_o  out  NUM_WAY  valid bits of probe_set_i; combinational.
REQ-009 SHALL have ports alloc_valid_i in 1, alloc_ready_o out 1, alloc_set_i in SET_BITS, alloc_tag_i in TAG_BITS  refill allocation request.
REQ-010 SHALL have ports evict_valid_o out 1, evict_ready_i in 1, evict_set_o out SET_BITS, evict_tag_o out TAG_BITS, evict_way_o out NUM_WAY (onehot)  dirty-victim writeback request.
REQ-011 SHALL have ports done_valid_o out 1, done_way_o out NUM_WAY (onehot)  allocation-complete strobe.
REQ-012 SHALL have ports mark_dirty_i in 1, mark_set_i in SET_BITS, mark_waymask_i in NUM_WAY  write-hit dirty marking.
REQ-013 SHALL have port invalidate_all_i  in  1  flash-clear of all valid and dirty bits.

Function
REQ-014 SHALL hold per set/way: tag, valid and dirty registers, plus one round-robin pointer per set (range 0..NUM_WAY-1).
REQ-015 SHALL implement FSM IDLE, SELECT, EVICT, WRITE; alloc_ready_o SHALL be 1 only in IDLE.
REQ-016 SHALL capture alloc_set_i/alloc_tag_i on alloc_valid_i && alloc_ready_o and move IDLE->SELECT.
REQ-017 SHALL in SELECT choose the victim: the lowest-index invalid way if any, else the way at the set's round-robin pointer; the victim SHALL be registered as onehot.
REQ-018 SHALL move SELECT->EVICT if the victim is valid and dirty, else SELECT->WRITE.
REQ-019 SHALL in EVICT drive evict_valid_o=1 with stable set/tag/way until evict_ready_i=1, then move to WRITE.
REQ-020 SHALL in WRITE set tag=captured tag, valid=1, dirty=0 for the victim, pulse done_valid_o for one cycle with done_way_o=victim, and return to IDLE.
REQ-021 SHALL advance the set's pointer by 1 (wrapping NUM_WAY-1->0) in WRITE only when the victim came from the pointer; filling an invalid way leaves it unchanged.
REQ-022 SHALL set dirty for every way in mark_waymask_i of mark_set_i that is valid, in any state; SELECT samples registered dirty bits, so a mark in the SELECT cycle is not seen.
REQ-023 SHALL give WRITE priority over mark_dirty_i on the same set/way, leaving dirty=0.
REQ-024 SHALL clear all valid/dirty bits on invalidate_all_i in any state; the FSM continues, and an entry written in the same cycle ends valid=1.
REQ-025 SHALL make the read port reflect register updates from the next cycle (no bypass).
REQ-026 SHALL accept a new request with minimum latency of 3 cycles (accept, SELECT, WRITE) without eviction.

Reset
REQ-027 SHALL on rst clear all valid, dirty and pointers, put the FSM in IDLE, and drive alloc_ready_o=1 and evict_valid_o=0, done_valid_o=0, done_way_o=0, evict_way_o=0, evict_set_o=0, evict_tag_o=0; tag contents SHALL be reset to 0.
REQ-028 SHALL abandon any in-flight allocation when rst asserts mid-operation, with no done pulse.

Configuration
REQ-029 SHALL implement macro TAG_ALLOC_WRITEBACK_EN: when defined, dirty tracking and the EVICT state exist as specified.
REQ-030 SHALL, when TAG_ALLOC_WRITEBACK_EN is undefined, ignore the mark_* inputs, tie evict_valid_o=0, and always go SELECT->WRITE.

Verification (NUM_SET=4, NUM_WAY=4, TAG_BITS=8, TAG_ALLOC_WRITEBACK_EN defined)
REQ-031 SHALL cover: four allocs to set 1 with tags 0x11..0x14 after reset -> done_way_o = 0001, 0010, 0100, 1000; probe set 1 gives valid 1111 and tags 0x14131211.
REQ-032 SHALL cover: a fifth alloc to set 1 with tag 0x55 -> victim way 0 (pointer 0), evict_valid_o=0, then pointer=1 and a sixth alloc picks way 1.
REQ-033 SHALL cover: mark set 1 way 2 dirty, pointer at 2, alloc tag 0x66 -> evict_valid_o=1 with tag 0x13 and way 0100, held 5 cycles with evict_ready_i=0; done follows ready by 1 cycle.
REQ-034 SHALL cover: invalidate_all_i during EVICT -> evict completes, way 2 ends valid with tag 0x66, and all other ways are invalid.
REQ-035 SHALL cover: rst asserted in SELECT -> no done pulse, alloc_ready_o=1, and all valid bits are 0 immediately.
REQ-036 SHALL cover: alloc_valid_i held during a busy FSM -> not accepted until IDLE, with exactly one done per handshake.
